// File: rtl/ts_packet_aligner.sv
// MPEG transport-stream sync aligner: hunts for 0x47 sync bytes at PKT_LEN spacing,
// locks after LOCK_CNT good syncs, drops after UNLOCK_CNT bad ones, forwards bytes while locked.
module ts_packet_aligner #(
    parameter int unsigned PKT_LEN    = 188,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ts_valid_in,
    input  logic       ts_sync_in,
    input  logic [7:0] ts_data_in,
    output logic       ts_valid_out,
    output logic       ts_sync_out,
    output logic [7:0] ts_data_out,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] err_count
);

    localparam int unsigned IDX_W  = $clog2(PKT_LEN);
    localparam int unsigned GCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MCNT_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [7:0]  SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2,
        S_LOSS   = 2'd3
    } state_t;

    state_t              st;
    logic [IDX_W-1:0]    idx;
    logic [GCNT_W-1:0]   good_cnt;
    logic [MCNT_W-1:0]   miss_cnt;

    // Upstream packet-start flag is deliberately not trusted for alignment.
    logic sync_in_unused;
    assign sync_in_unused = ts_sync_in;

    logic               at_sync_c;
    logic               good_c;
    logic [IDX_W-1:0]   idx_inc_c;
    logic [GCNT_W-1:0]  good_next_c;
    logic [MCNT_W-1:0]  miss_next_c;
    logic               lock_hit_c;
    logic               unlock_hit_c;
    logic [7:0]         err_inc_c;
    logic               fwd_c;

    always_comb begin
        at_sync_c    = (idx == '0);
        good_c       = (ts_data_in == SYNC_BYTE);
        idx_inc_c    = (idx == IDX_W'(PKT_LEN - 1)) ? '0 : idx + IDX_W'(1);
        good_next_c  = good_cnt + GCNT_W'(1);
        miss_next_c  = miss_cnt + MCNT_W'(1);
        lock_hit_c   = (good_next_c >= GCNT_W'(LOCK_CNT));
        unlock_hit_c = (miss_next_c >= MCNT_W'(UNLOCK_CNT));
        err_inc_c    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        // Forward iff the state after this byte is LOCKED or LOSS.
        fwd_c = 1'b0;
        if (ts_valid_in) begin
            case (st)
                S_VERIFY: fwd_c = at_sync_c && good_c && lock_hit_c;
                S_LOCKED: fwd_c = 1'b1;
                S_LOSS:   fwd_c = !(at_sync_c && !good_c && unlock_hit_c);
                default:  fwd_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_HUNT;
            idx       <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            err_count <= 8'h00;
            locked    <= 1'b0;
        end else if (ts_valid_in) begin
            case (st)
                S_HUNT: begin
                    if (good_c) begin
                        st       <= S_VERIFY;
                        idx      <= IDX_W'(1);
                        good_cnt <= GCNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    if (!at_sync_c) begin
                        idx <= idx_inc_c;
                    end else if (good_c) begin
                        idx      <= idx_inc_c;
                        good_cnt <= good_next_c;
                        if (lock_hit_c) begin
                            st       <= S_LOCKED;
                            locked   <= 1'b1;
                            miss_cnt <= '0;
                        end
                    end else begin
                        st       <= S_HUNT;
                        idx      <= '0;
                        good_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    idx <= idx_inc_c;
                    if (at_sync_c && !good_c) begin
                        st        <= S_LOSS;
                        miss_cnt  <= MCNT_W'(1);
                        err_count <= err_inc_c;
                    end
                end
                default: begin
                    if (at_sync_c && good_c) begin
                        idx      <= idx_inc_c;
                        st       <= S_LOCKED;
                        miss_cnt <= '0;
                    end else if (at_sync_c) begin
                        err_count <= err_inc_c;
                        miss_cnt  <= miss_next_c;
                        if (unlock_hit_c) begin
                            st       <= S_HUNT;
                            idx      <= '0;
                            good_cnt <= '0;
                            miss_cnt <= '0;
                            locked   <= 1'b0;
                        end else begin
                            idx <= idx_inc_c;
                        end
                    end else begin
                        idx <= idx_inc_c;
                    end
                end
            endcase
        end
    end

    // Output stage: one-cycle registered forward, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_valid_out <= 1'b0;
            ts_sync_out  <= 1'b0;
            ts_data_out  <= 8'h00;
        end else begin
            ts_valid_out <= fwd_c;
            ts_sync_out  <= fwd_c && at_sync_c;
            if (fwd_c) begin
                ts_data_out <= ts_data_in;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Scoreboard bench for ts_packet_aligner: directed packet streams, expected forwards
// queued at stimulus time and popped by an independent output monitor.
module tb_ts_packet_aligner;

    localparam int unsigned PKT_LEN = 188;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ts_valid_in = 1'b0;
    logic       ts_sync_in = 1'b0;
    logic [7:0] ts_data_in = 8'h00;
    logic       ts_valid_out;
    logic       ts_sync_out;
    logic [7:0] ts_data_out;
    logic       locked;
    logic [1:0] state;
    logic [7:0] err_count;

    ts_packet_aligner #(.PKT_LEN(PKT_LEN), .LOCK_CNT(3), .UNLOCK_CNT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ts_valid_in  (ts_valid_in),
        .ts_sync_in   (ts_sync_in),
        .ts_data_in   (ts_data_in),
        .ts_valid_out (ts_valid_out),
        .ts_sync_out  (ts_sync_out),
        .ts_data_out  (ts_data_out),
        .locked       (locked),
        .state        (state),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sync;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         seed = 0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one accepted byte; returns #1 after the edge that samples it.
    task automatic drive(input logic [7:0] d, input bit fwd, input bit sy);
        exp_t e;
        ts_valid_in = 1'b1;
        ts_data_in  = d;
        ts_sync_in  = 1'($urandom_range(0, 1));
        if (fwd) begin
            e.data = d;
            e.sync = sy;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ts_valid_in = 1'b0;
        ts_data_in  = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    // One packet: sync byte sb, then payload with bit7 set so it never looks like 0x47.
    task automatic send_pkt(input logic [7:0] sb, input bit f0, input bit frest,
                            input logic [1:0] st0, input logic [7:0] err0,
                            input bit gap, input string nm);
        drive(sb, f0, 1'b1);
        chk({nm, " state"}, 32'(state), 32'(st0));
        chk({nm, " locked"}, 32'(locked), 32'(st0[1]));
        chk({nm, " err_count"}, 32'(err_count), 32'(err0));
        chk({nm, " valid_out"}, 32'(ts_valid_out), 32'(f0));
        if (gap) idle();
        for (int i = 1; i < int'(PKT_LEN); i++) begin
            drive({1'b1, 7'(i + seed)}, frest, 1'b0);
            if (gap) idle();
        end
        chk({nm, " end state"}, 32'(state), 32'(st0));
        seed++;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, " state"}, 32'(state), 32'd0);
        chk({nm, " locked"}, 32'(locked), 32'd0);
        chk({nm, " err_count"}, 32'(err_count), 32'd0);
        chk({nm, " valid_out"}, 32'(ts_valid_out), 32'd0);
        chk({nm, " sync_out"}, 32'(ts_sync_out), 32'd0);
        chk({nm, " data_out"}, 32'(ts_data_out), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare every forwarded byte; idle cycles must hold data, drop sync.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_data = 8'h00;
            end else if (ts_valid_out) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fwd: got data %0h expected no output", ts_data_out);
                end else begin
                    e = q.pop_front();
                    chk("fwd data", 32'(ts_data_out), 32'(e.data));
                    chk("fwd sync", 32'(ts_sync_out), 32'(e.sync));
                end
                last_data = ts_data_out;
            end else begin
                chk("idle sync_out", 32'(ts_sync_out), 32'd0);
                chk("idle data hold", 32'(ts_data_out), 32'(last_data));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        release_reset();

        // Junk in HUNT is neither forwarded nor a sync candidate.
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h12, 1'b0, 1'b0);
        chk("hunt junk state", 32'(state), 32'd0);

        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "acq1");
        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "acq2");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd0, 1'b0, "acq3");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd0, 1'b0, "locked4");

        send_pkt(8'h46, 1'b1, 1'b1, 2'd3, 8'd1, 1'b0, "corrupt");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd1, 1'b0, "recover");

        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd1, 1'b1, "gapped");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd1, 1'b0, "post_gap");

        send_pkt(8'h00, 1'b1, 1'b1, 2'd3, 8'd2, 1'b0, "loss1");
        send_pkt(8'hB8, 1'b1, 1'b1, 2'd3, 8'd3, 1'b0, "loss2");
        send_pkt(8'h46, 1'b0, 1'b0, 2'd0, 8'd4, 1'b0, "loss3");
        idle();

        rst_n = 1'b0;
        #1;
        check_reset_vals("reset2");
        release_reset();

        // False sync at offset 5; the next checked position is not 0x47.
        for (int k = 0; k < 5; k++) drive(8'h80 + 8'(k), 1'b0, 1'b0);
        drive(8'h47, 1'b0, 1'b0);
        chk("false sync verify", 32'(state), 32'd1);
        for (int i = 1; i < int'(PKT_LEN); i++) drive(8'h90, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        chk("false sync hunt", 32'(state), 32'd0);
        chk("false sync err", 32'(err_count), 32'd0);
        chk("false sync locked", 32'(locked), 32'd0);

        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "reacq1");
        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "reacq2");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd0, 1'b0, "reacq3");

        // Partial packet, reset arrives while byte 100 is on the bus.
        drive(8'h47, 1'b1, 1'b1);
        for (int i = 1; i < 100; i++) drive({1'b1, 7'(i + seed)}, 1'b1, 1'b0);
        ts_valid_in = 1'b1;
        ts_data_in  = 8'hE4;
        #6;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid reset");
        ts_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid reset queue drained", 32'(q.size()), 32'd0);
        chk("mid reset valid held low", 32'(ts_valid_out), 32'd0);
        release_reset();

        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "post_rst1");
        send_pkt(8'h47, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0, "post_rst2");
        send_pkt(8'h47, 1'b1, 1'b1, 2'd2, 8'd0, 1'b0, "post_rst3");
        repeat (4) idle();
        chk("final queue empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ts_packet_aligner.md
TS_PACKET_ALIGNER -- requirements
Module: ts_packet_aligner

Interface
REQ-001 Parameter PKT_LEN, default 188, SHALL be the transport packet length in bytes.
REQ-002 Parameter LOCK_CNT, default 3, SHALL be the number of consecutive good sync bytes required to lock.
REQ-003 Parameter UNLOCK_CNT, default 3, SHALL be the number of consecutive bad sync bytes that drops lock.
REQ-004 CLOCK  in  1  SHALL be the single clock; all logic rising-edge.
REQ-005 RESET  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 TS_VALID_IN  in  1  SHALL qualify TS_DATA_IN; one byte is accepted per cycle when high.
REQ-007 TS_SYNC_IN  in  1  SHALL be the upstream packet-start flag; it is ignored for alignment decisions.
REQ-008 TS_DATA_IN  in  8  SHALL be the input byte.
REQ-009 TS_VALID_OUT  out  1  SHALL qualify TS_DATA_OUT.
REQ-010 TS_SYNC_OUT  out  1  SHALL mark byte 0 of each forwarded packet.
REQ-011 TS_DATA_OUT  out  8  SHALL be the forwarded byte.
REQ-012 LOCKED  out  1  SHALL be high in states LOCKED and LOSS.
REQ-013 STATE  out  2  SHALL be the state encoding HUNT=0, VERIFY=1, LOCKED=2, LOSS=3, for 7-segment display.
REQ-014 ERR_COUNT  out  8  SHALL count bad sync bytes seen while in LOCKED or LOSS, saturating at 255.

Function
REQ-015 The block SHALL keep a byte index IDX in 0..PKT_LEN-1, advancing only on accepted bytes, wrapping PKT_LEN-1 -> 0.
REQ-016 A sync check SHALL occur on an accepted byte when IDX==0 in VERIFY, LOCKED or LOSS; the check is good iff TS_DATA_IN==8'h47.
REQ-017 HUNT: accepted byte 8'h47 -> VERIFY, IDX:=1, good count:=1; any other byte -> stay HUNT, IDX held at 0.
REQ-018 VERIFY: good check -> good count+1; if the result reaches LOCK_CNT -> LOCKED.
REQ-019 VERIFY: bad check -> HUNT, IDX:=0, good count:=0; the offending byte is not re-examined as a new sync candidate.
REQ-020 LOCKED: bad check -> LOSS, miss count:=1, ERR_COUNT+1; good check -> stay.
REQ-021 LOSS: good check -> LOCKED, miss count:=0.
REQ-022 LOSS: bad check -> ERR_COUNT+1, miss count+1; if the result reaches UNLOCK_CNT -> HUNT, IDX:=0.
REQ-023 IDX SHALL advance normally through sync checks in VERIFY, LOCKED and LOSS, good or bad.
REQ-024 An accepted byte SHALL be forwarded iff the state after processing it is LOCKED or LOSS, so the sync byte that completes lock is forwarded and the byte that causes the drop to HUNT is not.
REQ-025 Forwarded outputs SHALL be registered with exactly 1-cycle latency: TS_VALID_OUT=1, TS_DATA_OUT=the input byte, TS_SYNC_OUT=(IDX==0 for that byte).
REQ-026 Bad sync bytes in LOSS SHALL be forwarded unmodified with TS_SYNC_OUT=1.
REQ-027 Cycles with TS_VALID_IN=0 SHALL change no state or counters and SHALL give TS_VALID_OUT=0 and TS_SYNC_OUT=0 on the next cycle.
REQ-028 When TS_VALID_OUT=0, TS_DATA_OUT SHALL hold its last value.
REQ-029 STATE and LOCKED SHALL be registered and SHALL change on the same edge as the state transition.

Reset
REQ-030 While RESET=0, the block SHALL hold STATE=HUNT, IDX=0, good and miss counts=0, ERR_COUNT=0, TS_VALID_OUT=0, TS_SYNC_OUT=0, TS_DATA_OUT=8'h00 and LOCKED=0.
REQ-031 Reset asserted mid-packet SHALL take effect immediately, with no partial packet forwarded after assertion.
REQ-032 After release, the first accepted byte SHALL be evaluated as in HUNT.

Verification
REQ-033 Lock acquisition: 3 clean 188-byte packets with 0x47 at byte 0 -> STATE 0->1->2; LOCKED rises on the 3rd sync byte; TS_VALID_OUT/TS_SYNC_OUT=1 one cycle later.
REQ-034 False sync: 0x47 at offset 5, next checked byte 0x00 -> VERIFY then HUNT; no output valid; ERR_COUNT=0.
REQ-035 Single corruption: locked stream, one packet with sync byte 0x46 -> LOSS, ERR_COUNT=1, byte forwarded with TS_SYNC_OUT=1; next good sync -> LOCKED.
REQ-036 Lock loss: 3 consecutive bad syncs -> HUNT on the 3rd; that byte not forwarded; ERR_COUNT=3.
REQ-037 Gapped input: TS_VALID_IN toggling 1/0 across a locked stream -> identical output byte sequence with gaps; IDX unaffected.
REQ-038 Reset mid-packet at byte 100 while locked -> all outputs 0 asynchronously; re-lock requires 3 new good packets.
